// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with block refill.
// A hit is answered combinationally. A miss stalls fetch while the whole
// 128-bit block is read from instruction memory.
module icache_dm #(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [31:0]   ADDRESS,
  output logic [31:0]   INSTRUCTION,
  output logic          BUSYWAIT,
  output logic          MEM_READ,
  output logic [27:0]   MEM_ADDRESS,
  input  logic [127:0]  MEM_READDATA,
  input  logic          MEM_BUSYWAIT
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 28 - INDEX_BITS;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ   = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic                  busy;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [127:0]          data_mem [LINES];

  logic [27:0]           miss_addr;
  logic [127:0]          fill_data;
  logic                  mem_read_q;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      addr_tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_W-1:0]      miss_tag;
  logic                  hit;
  logic [31:0]           word;
  logic                  unused_addr_bits;

  // Address fields of the current fetch and of the latched miss
  assign index      = ADDRESS[3+INDEX_BITS:4];
  assign addr_tag   = ADDRESS[31:4+INDEX_BITS];
  assign miss_index = miss_addr[INDEX_BITS-1:0];
  assign miss_tag   = miss_addr[27:INDEX_BITS];
  assign unused_addr_bits = ^ADDRESS[1:0];

  // Lookup and word select for the current address
  always_comb begin
    hit  = valid[index] && (tag_mem[index] == addr_tag);
    word = data_mem[index][{ADDRESS[3:2], 5'b0} +: 32];
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and stall decode
  always_comb begin
    next_state = state;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = !hit;
        if (!hit) next_state = READ;
      end
      READ: begin
        if (!MEM_BUSYWAIT) next_state = UPDATE;
      end
      UPDATE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Fetch-side outputs are forced quiet while reset is held
  always_comb begin
    BUSYWAIT    = RESET ? 1'b0  : busy;
    INSTRUCTION = RESET ? 32'b0 : word;
  end

  // Memory read request tracks the READ state as a flop
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) mem_read_q <= 1'b0;
    else       mem_read_q <= (next_state == READ);
  end

  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = miss_addr;

  // Latch the missing block address when leaving IDLE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                         miss_addr <= 28'b0;
    else if (state == IDLE && !hit)    miss_addr <= ADDRESS[31:4];
  end

  // Capture the returned block once memory stops stalling
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                              fill_data <= 128'b0;
    else if (state == READ && !MEM_BUSYWAIT) fill_data <= MEM_READDATA;
  end

  // Valid bits: cleared by reset, set when a line is installed
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                valid <= '0;
    else if (state == UPDATE) valid[miss_index] <= 1'b1;
  end

  // Tag and data arrays: install the refilled line, evicting unconditionally
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      tag_mem[miss_index]  <= miss_tag;
      data_mem[miss_index] <= fill_data;
    end
  end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache that answers the fetch stage's PC requests. It returns `INSTRUCTION` and holds `BUSYWAIT` high while a line is missing. On a miss it refills the whole block from instruction memory over a busywait read handshake. It sits between `if_unit` (fetch side) and the instruction memory model (memory side).

## Interface
- `INDEX_BITS`, default 3: log2 of the line count (8 lines). Tag width = 28 − `INDEX_BITS`.
- `CLK  in  1`: clock; all state updates on posedge.
- `RESET  in  1`: reset, asynchronous, active-high.
- `ADDRESS  in  32`: fetch address (PC). Bits [1:0] ignored, bits [3:2] = word offset, bits [3+INDEX_BITS:4] = index, remaining upper bits = tag.
- `INSTRUCTION  out  32`: selected instruction word; valid when `BUSYWAIT`=0.
- `BUSYWAIT  out  1`: fetch-side stall.
- `MEM_READ  out  1`: block read request to instruction memory.
- `MEM_ADDRESS  out  28`: block address (byte address >> 4).
- `MEM_READDATA  in  128`: returned block. Word 0 = bits [31:0], word 3 = bits [127:96].
- `MEM_BUSYWAIT  in  1`: memory busy; data is valid on the first posedge where it is 0 while `MEM_READ`=1.

## Operation
- Storage per line: valid bit, tag, 128-bit data. No dirty bits; no writes from fetch side.
- Hit = `valid[index]` && `tag[index]` == `ADDRESS` tag, evaluated combinationally from current `ADDRESS`.
- `INSTRUCTION` = data[index] word selected by `ADDRESS[3:2]`. It is combinational and may be garbage on a miss.
- FSM states:
  - IDLE: `BUSYWAIT` = !hit. On a miss, latch `ADDRESS[31:4]` into `miss_addr` and go to READ. On a hit, stay in IDLE.
  - READ: `MEM_READ`=1, `MEM_ADDRESS`=`miss_addr`, `BUSYWAIT`=1. At a posedge with `MEM_BUSYWAIT`=0, capture `MEM_READDATA` and go to UPDATE. Otherwise stay in READ.
  - UPDATE: `MEM_READ`=0, `BUSYWAIT`=1. At the posedge, write data, tag and valid=1 into line `miss_addr` index, then go to IDLE.
- `ADDRESS` may change during READ/UPDATE (branch redirect). The refill always completes for the latched `miss_addr`. No abort. IDLE then re-evaluates the new `ADDRESS`, which may miss again.
- A new miss that evicts a valid line overwrites it unconditionally.
- PC = 0xFFFFFFFC after reset is treated as an ordinary address. It misses and refills block 0x0FFFFFFF.

## Timing
- Hit: `INSTRUCTION` valid and `BUSYWAIT`=0 combinationally in the same cycle `ADDRESS` is presented. Zero-cycle latency.
- Miss penalty: `BUSYWAIT` goes high combinationally in the presenting cycle. Then 1 edge IDLE→READ, N edges in READ (N = memory wait cycles, ≥1), 1 edge UPDATE→IDLE. `BUSYWAIT` falls in the first IDLE cycle after UPDATE.
- With a 1-cycle memory, a miss stalls 3 cycles; the hit is seen in the 4th cycle.
- `MEM_READ` is registered from state: high exactly while state = READ.
- Reset (asynchronous): state=IDLE, all valid bits=0, `miss_addr`=0, `MEM_READ`=0, `MEM_ADDRESS`=0.
  - While `RESET`=1: `BUSYWAIT` forced 0 and `INSTRUCTION` forced 0.
  - Reset mid-refill drops `MEM_READ` immediately and discards the partial refill.
- `MEM_BUSYWAIT` is ignored outside READ.

## Test plan
- Reset then cold fetch:
  - Stimulus: `ADDRESS`=0x00000000, memory returns block {0x00400093, 0x00100113, 0x002081B3, 0x00000013} after 2 wait cycles.
  - Required: `BUSYWAIT`=1 for 4 cycles, `MEM_ADDRESS`=0x0000000 while `MEM_READ`=1, then `INSTRUCTION`=0x00400093 with `BUSYWAIT`=0.
- Same-block hits: after the fill, `ADDRESS`=0x4, 0x8, 0xC on consecutive cycles → `INSTRUCTION`=0x00100113, 0x002081B3, 0x00000013; `BUSYWAIT`=0 throughout; `MEM_READ` never asserts.
- Conflict eviction:
  - Stimulus: fill 0x00000000, then fetch 0x00000080 (same index 0, different tag), then 0x00000000 again.
  - Required: two further refills, with `MEM_ADDRESS`=0x0000008 then 0x0000000.
- Redirect mid-refill:
  - Stimulus: miss on 0x00000010, change `ADDRESS` to 0x00000020 while in READ.
  - Required: the refill completes for `MEM_ADDRESS`=0x0000001, then a second refill is issued for 0x0000002. Afterwards line 1 and line 2 are both valid.
- Reset during READ: assert `RESET` while `MEM_READ`=1 → `MEM_READ`=0 immediately; a subsequent fetch of the same address misses (valid cleared).
- Post-reset PC: `ADDRESS`=0xFFFFFFFC → miss with `MEM_ADDRESS`=0xFFFFFFF, then a hit returning word 3 of the block.
